// File: rtl/wallace_26x24_product.sv
// Unsigned 24x26 multiplier: Wallace carry-save reduction tree feeding a
// single carry-propagate adder, with a registered 50-bit product.
module wallace_26x24_product (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] a,
    input  logic [25:0] b,
    input  logic        in_valid,
    output logic [49:0] z,
    output logic        out_valid
);

    localparam int unsigned A_W    = 24;
    localparam int unsigned B_W    = 26;
    localparam int unsigned Z_W    = A_W + B_W;
    localparam int unsigned LEVELS = 7;
    localparam int unsigned GROUPS = A_W / 3;

    // Row count entering a given reduction level (24,16,11,8,6,4,3 -> 2).
    function automatic int unsigned rows_at(input int unsigned lvl);
        int unsigned n;
        n = A_W;
        for (int unsigned k = 0; k < lvl; k++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    logic [Z_W-1:0] rows [A_W];
    logic [Z_W-1:0] nxt  [A_W];
    logic [Z_W-1:0] x;
    logic [Z_W-1:0] y;
    logic [Z_W-1:0] w;
    logic [Z_W-1:0] product_c;

    // Partial products, then 3:2 compression level by level down to two rows.
    // Leftover rows of each level (n mod 3) pass straight through; bit lanes
    // where only two inputs are non-zero reduce to half adders after mapping.
    always_comb begin
        for (int i = 0; i < A_W; i++) begin
            rows[i] = Z_W'(b & {B_W{a[i]}}) << i;
        end
        x = '0;
        y = '0;
        w = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int r = 0; r < A_W; r++) begin
                nxt[r] = '0;
            end
            for (int g = 0; g < GROUPS; g++) begin
                if (g < int'(rows_at(lvl) / 3)) begin
                    x = rows[3*g];
                    y = rows[3*g+1];
                    w = rows[3*g+2];
                    nxt[2*g]   = x ^ y ^ w;
                    nxt[2*g+1] = ((x & y) | (x & w) | (y & w)) << 1;
                end
            end
            for (int r = 0; r < A_W; r++) begin
                if (r >= int'(3 * (rows_at(lvl) / 3)) && r < int'(rows_at(lvl))) begin
                    nxt[r - int'(rows_at(lvl) / 3)] = rows[r];
                end
            end
            for (int r = 0; r < A_W; r++) begin
                rows[r] = nxt[r];
            end
        end
        // Final carry-propagate add; carry out of the top bit is always zero.
        product_c = rows[0] + rows[1];
    end

    // Output register: capture on in_valid, hold otherwise, clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z <= product_c;
            end
        end
    end

endmodule

// File: tb/tb_wallace_26x24_product.sv
// Self-checking bench for wallace_26x24_product: directed vector table,
// back-to-back stream, asynchronous reset sequence and random regression.
module tb_wallace_26x24_product;

    logic        clk;
    logic        rst;
    logic [23:0] a;
    logic [25:0] b;
    logic        in_valid;
    logic [49:0] z;
    logic        out_valid;

    int checks;
    int failures;

    // Reference model state: the product of the last accepted operands.
    logic [49:0] mdl_z;
    logic        mdl_v;

    typedef struct {
        logic [23:0] a;
        logic [25:0] b;
        logic        v;
        logic [49:0] exp_z;
        logic        exp_v;
    } vec_t;

    vec_t vecs [8];

    wallace_26x24_product dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .z         (z),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [49:0] act, input logic [49:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply operands, let one rising edge pass, then sample.
    task automatic step(input logic [23:0] ta, input logic [25:0] tb_, input logic tv);
        a        = ta;
        b        = tb_;
        in_valid = tv;
        @(posedge clk);
        if (tv) begin
            mdl_z = 50'(64'(ta) * 64'(tb_));
        end
        mdl_v = tv;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mdl_z    = '0;
        mdl_v    = 1'b0;
        rst      = 1'b1;
        a        = 24'hFFFFFF;
        b        = 26'h3FFFFFF;
        in_valid = 1'b1;

        vecs[0] = '{24'hFFFFFF, 26'h3FFFFFF, 1'b1, 50'h3FFFFFB000001, 1'b1};
        vecs[1] = '{24'h000000, 26'h3FFFFFF, 1'b1, 50'h0,             1'b1};
        vecs[2] = '{24'h000001, 26'h2AAAAAA, 1'b1, 50'h2AAAAAA,       1'b1};
        vecs[3] = '{24'hFFFFFF, 26'h0000001, 1'b1, 50'hFFFFFF,        1'b1};
        vecs[4] = '{24'h800000, 26'h2000000, 1'b1, 50'h1000000000000, 1'b1};
        vecs[5] = '{24'h000003, 26'h0000005, 1'b1, 50'hF,             1'b1};
        vecs[6] = '{24'h123456, 26'h1ABCDEF, 1'b0, 50'hF,             1'b0};
        vecs[7] = '{24'hABCDEF, 26'h3000001, 1'b0, 50'hF,             1'b0};

        // Reset held across edges with in_valid high: nothing captured.
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", z, 50'h0);
        check("reset_valid", 50'(out_valid), 50'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table applied back-to-back, then two idle cycles with
        // changing operands that must leave z untouched.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            step(vecs[i].a, vecs[i].b, vecs[i].v);
            check($sformatf("vec%0d_z", i), z, vecs[i].exp_z);
            check($sformatf("vec%0d_valid", i), 50'(out_valid), 50'(vecs[i].exp_v));
        end

        // Asynchronous reset between edges after a valid product.
        @(negedge clk);
        step(24'h00ABCD, 26'h0001234, 1'b1);
        check("pre_rst_z", z, 50'(64'h00ABCD * 64'h0001234));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_z", z, 50'h0);
        check("async_rst_valid", 50'(out_valid), 50'h0);
        @(posedge clk);
        #1;
        check("rst_hold_z", z, 50'h0);
        check("rst_hold_valid", 50'(out_valid), 50'h0);
        @(negedge clk);
        rst   = 1'b0;
        mdl_z = '0;
        mdl_v = 1'b0;
        step(24'h2, 26'h3, 1'b1);
        check("post_rst_z", z, 50'h6);
        check("post_rst_valid", 50'(out_valid), 50'h1);

        // Random regression against the arithmetic model, with gaps.
        for (int i = 0; i < 10000; i++) begin
            logic [23:0] ra;
            logic [25:0] rb;
            logic        rv;
            @(negedge clk);
            ra = 24'($urandom);
            rb = 26'($urandom);
            case ($urandom_range(0, 15))
                0: ra = 24'hFFFFFF;
                1: rb = 26'h3FFFFFF;
                2: ra = 24'h0;
                default: ;
            endcase
            rv = ($urandom_range(0, 3) != 0);
            step(ra, rb, rv);
            check("rand_z", z, mdl_z);
            check("rand_valid", 50'(out_valid), 50'(mdl_v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
